// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: round-robin or fixed priority,
// plus a port-1 lock for atomic read-modify-write sequences.

module mem_arbiter_rdport #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_fire,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    logic vld_pipe;

    // rdata keeps the last returned word until the next read on this port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= 1'b0;
            rdata    <= '0;
        end else begin
            vld_pipe <= rd_fire;
            if (rd_fire) rdata <= rd_data;
        end
    end

    assign rvalid = vld_pipe;
endmodule

module mem_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              lock1_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } port_req_t;

    typedef enum logic {
        OWN_NONE,
        OWN_LOCKED1
    } owner_t;

    port_req_t [NUM_PORTS-1:0]             preq;
    logic      [NUM_PORTS-1:0]             gnt;
    logic      [NUM_PORTS-1:0]             rd_fire;
    logic      [NUM_PORTS-1:0]             rvalid;
    logic      [NUM_PORTS-1:0][DATA_W-1:0] rdata;
    owner_t                                owner_q;
    logic                                  last_q;

    assign preq[0] = {req0_i, we0_i, addr0_i, wdata0_i};
    assign preq[1] = {req1_i, we1_i, addr1_i, wdata1_i};

    // While port 1 holds the lock, port 0 stalls even if port 1 is idle
    always_comb begin
        gnt = '0;
        if (owner_q == OWN_LOCKED1) begin
            gnt[1] = preq[1].req;
        end else if (preq[0].req && preq[1].req) begin
            if (FIXED_PRIO || !last_q) gnt[1] = 1'b1;
            else                       gnt[0] = 1'b1;
        end else begin
            gnt[0] = preq[0].req;
            gnt[1] = preq[1].req;
        end
    end

    always_comb begin
        mem_a_o  = '0;
        mem_wd_o = '0;
        mem_we_o = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                mem_a_o  = preq[p].addr;
                mem_wd_o = preq[p].wdata;
                mem_we_o = preq[p].we & ~rst_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
        end else begin
            if (|gnt) last_q <= gnt[1];
            case (owner_q)
                OWN_NONE:    if (gnt[1] && lock1_i) owner_q <= OWN_LOCKED1;
                OWN_LOCKED1: if (!lock1_i)          owner_q <= OWN_NONE;
                default:                            owner_q <= OWN_NONE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        assign rd_fire[p] = gnt[p] & ~preq[p].we;
        mem_arbiter_rdport #(.DATA_W(DATA_W)) u_rd (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .rd_fire (rd_fire[p]),
            .rd_data (mem_rd_i),
            .rvalid  (rvalid[p]),
            .rdata   (rdata[p])
        );
    end

    assign gnt0_o    = gnt[0];
    assign gnt1_o    = gnt[1];
    assign rvalid0_o = rvalid[0];
    assign rvalid1_o = rvalid[1];
    assign rdata0_o  = rdata[0];
    assign rdata1_o  = rdata[1];
endmodule
